// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: register-file read bus plus dump stream, seen from the reader side
interface regfile_dump_reader_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Read_Register_1_o;
  logic [ADDR_W-1:0] Read_Register_2_o;
  logic [N-1:0]      Read_Data_1_i;
  logic [N-1:0]      Read_Data_2_i;
  logic              Dump_Valid_o;
  logic              Dump_Ready_i;
  logic [ADDR_W-1:0] Dump_Index_o;
  logic [N-1:0]      Dump_Data_o;
  logic              Dump_Last_o;
  modport master (
    output Read_Register_1_o, Read_Register_2_o, Dump_Valid_o, Dump_Index_o, Dump_Data_o, Dump_Last_o,
    input  Read_Data_1_i, Read_Data_2_i, Dump_Ready_i
  );
  modport slave (
    input  Read_Register_1_o, Read_Register_2_o, Dump_Valid_o, Dump_Index_o, Dump_Data_o, Dump_Last_o,
    output Read_Data_1_i, Read_Data_2_i, Dump_Ready_i
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: drains a register file pairwise into a valid/ready stream with a running XOR checksum
module regfile_dump_reader #(
  parameter int N        = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start_i,
  input  logic                 Abort_i,
  regfile_dump_reader_if.master bus,
  output logic                 Busy_o,
  output logic                 Done_o,
  output logic [N-1:0]         Checksum_o
);
  localparam int KW = ADDR_W - 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_REGS / 2 - 1);
  typedef enum logic [2:0] {IDLE, READ, SEND_A, SEND_B, DONE} state_t;
  state_t            state_q;
  logic [KW-1:0]     k_q;
  logic [N-1:0]      b_q;
  logic [N-1:0]      data_q;
  logic [ADDR_W-1:0] idx_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic [N-1:0]      cks_q;
  logic              acc;
  assign acc                   = valid_q & bus.Dump_Ready_i;
  assign bus.Read_Register_1_o = {k_q, 1'b0};
  assign bus.Read_Register_2_o = {k_q, 1'b1};
  assign bus.Dump_Valid_o      = valid_q;
  assign bus.Dump_Index_o      = idx_q;
  assign bus.Dump_Data_o       = data_q;
  assign bus.Dump_Last_o       = last_q;
  assign Busy_o                = busy_q;
  assign Done_o                = done_q;
  assign Checksum_o            = cks_q;
  // data_q carries the word on offer, so the checksum folds in exactly what the sink accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cks_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (Abort_i && state_q inside {READ, SEND_A, SEND_B}) begin
        state_q <= IDLE;
        k_q     <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (Start_i) begin
            cks_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
          READ: begin
            data_q  <= bus.Read_Data_1_i;
            b_q     <= bus.Read_Data_2_i;
            idx_q   <= {k_q, 1'b0};
            valid_q <= 1'b1;
            state_q <= SEND_A;
          end
          SEND_A: if (acc) begin
            cks_q   <= cks_q ^ data_q;
            data_q  <= b_q;
            idx_q   <= {k_q, 1'b1};
            last_q  <= k_q == K_LAST;
            state_q <= SEND_B;
          end
          SEND_B: if (acc) begin
            cks_q   <= cks_q ^ data_q;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= k_q == K_LAST;
            k_q     <= k_q == K_LAST ? k_q : k_q + 1'b1;
            state_q <= k_q == K_LAST ? DONE : READ;
          end
          DONE: begin
            k_q     <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: scenario table plus randomized dumps checked against a word-order/XOR model
module tb_regfile_dump_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [31:0] cks;
  logic [31:0] regs [32];
  int          checks = 0;
  int          errors = 0;

  regfile_dump_reader_if #(.N(32), .ADDR_W(5)) bus ();

  regfile_dump_reader #(.N(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .Start_i(start), .Abort_i(abort), .bus(bus),
    .Busy_o(busy), .Done_o(done), .Checksum_o(cks)
  );

  always #5 clk = ~clk;

  assign bus.Read_Data_1_i = regs[bus.Read_Register_1_o];
  assign bus.Read_Data_2_i = regs[bus.Read_Register_2_o];

  typedef struct {
    bit          rnd;
    int          stall_idx;
    int          stall_len;
    int          abort_idx;
    int          reset_idx;
    int          start_mid;
    bit          start_done;
    logic [31:0] exp_cks;
  } row_t;

  row_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.Dump_Valid_o, 0);
    check({tag, "_index"}, bus.Dump_Index_o, 0);
    check({tag, "_data"}, bus.Dump_Data_o, 0);
    check({tag, "_last"}, bus.Dump_Last_o, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cks"}, cks, 0);
    check({tag, "_rr1"}, bus.Read_Register_1_o, 0);
    check({tag, "_rr2"}, bus.Read_Register_2_o, 1);
  endtask

  task automatic preload();
    foreach (regs[i]) regs[i] = 32'h0;
    regs[2]  = 32'd7;
    regs[4]  = 32'd20;
    regs[25] = 32'd6;
    regs[31] = 32'd78;
  endtask

  task automatic run(input row_t r);
    int          exp_idx = 0;
    int          stalls = 0;
    int          cyc = 1;
    int          bad = 0;
    int          stall_left = r.stall_len;
    logic [31:0] mcks = 32'h0;
    logic        pv = 1'b0;
    logic        pacc = 1'b0;
    logic [4:0]  pidx = '0;
    logic [31:0] pdata = '0;
    logic        plast = 1'b0;
    logic        v;
    bit          fin = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cks_clear", cks, 0);
    check("busy_start", busy, 1);
    while (!fin) begin
      v = bus.Dump_Valid_o;
      if (pv && !pacc && (v !== 1'b1 || bus.Dump_Index_o !== pidx ||
                          bus.Dump_Data_o !== pdata || bus.Dump_Last_o !== plast)) bad++;
      if (v === 1'b1 && (bus.Dump_Index_o !== exp_idx[4:0] || bus.Dump_Data_o !== regs[exp_idx] ||
                         bus.Dump_Last_o !== (exp_idx == 31))) bad++;
      if (busy !== 1'b1) bad++;
      if (cyc > 300) begin
        check("timeout_cycles", cyc, 0);
        fin = 1;
      end else if (done === 1'b1) begin
        check("done_words", exp_idx, 32);
        check("done_cycle", cyc, 49 + stalls);
        check("done_cks", cks, r.rnd ? mcks : r.exp_cks);
        check("done_valid", v, 0);
        check("word_errs", bad, 0);
        start = r.start_done;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("idle_rr1", bus.Read_Register_1_o, 0);
        check("idle_cks_hold", cks, r.rnd ? mcks : r.exp_cks);
        fin = 1;
      end else if (v === 1'b1 && exp_idx == r.reset_idx) begin
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        check("word_errs", bad, 0);
        @(negedge clk);
        reset = 1'b0;
        fin = 1;
      end else begin
        abort = v && exp_idx == r.abort_idx;
        bus.Dump_Ready_i = r.rnd ? ($urandom_range(0, 3) != 0) :
                           !(v && exp_idx == r.stall_idx && stall_left > 0);
        start = v && exp_idx == r.start_mid;
        if (v && !bus.Dump_Ready_i) begin
          stalls++;
          stall_left--;
        end
        pv = v;
        pacc = v && bus.Dump_Ready_i;
        pidx = bus.Dump_Index_o;
        pdata = bus.Dump_Data_o;
        plast = bus.Dump_Last_o;
        if (v && bus.Dump_Ready_i && !abort) begin
          mcks ^= regs[exp_idx];
          exp_idx++;
        end
        @(negedge clk);
        cyc++;
        start = 1'b0;
        if (abort) begin
          abort = 1'b0;
          check("abort_valid", bus.Dump_Valid_o, 0);
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          check("abort_cks", cks, r.exp_cks);
          check("word_errs", bad, 0);
          fin = 1;
        end
      end
    end
    bus.Dump_Ready_i = 1'b1;
  endtask

  initial begin
    bus.Dump_Ready_i = 1'b1;
    preload();
    //            rnd stall len abort reset smid sdone cks
    tbl[0] = '{0, -1, 0, -1, -1, -1, 0, 32'h5B};
    tbl[1] = '{0,  4, 3, -1, -1, -1, 0, 32'h5B};
    tbl[2] = '{0, -1, 0, -1, -1,  6, 1, 32'h5B};
    tbl[3] = '{0, -1, 0,  5, -1, -1, 0, 32'h13};
    tbl[4] = '{0, -1, 0, -1, 25, -1, 0, 32'h0};
    tbl[5] = '{0, -1, 0, -1, -1, -1, 0, 32'h5B};
    tbl[6] = '{0, -1, 0, -1, -1, -1, 0, 32'h5B};
    tbl[7] = '{1, -1, 0, -1, -1, -1, 0, 32'h0};
    tbl[8] = '{1, -1, 0, -1, -1, -1, 1, 32'h0};
    tbl[9] = '{1, -1, 0, -1, -1, -1, 0, 32'h0};
    reset = 1'b1;
    #2 check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_start_busy", busy, 0);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rnd) foreach (regs[j]) regs[j] = $urandom;
      run(tbl[i]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
